// File: rtl/trng_seed_packer.sv
// trng_seed_packer: read side of the TRNG byte FIFO. Pops entropy bytes one
// at a time (registered FIFO read port, data valid the cycle after a pop) and
// packs WORD_BYTES of them, first byte least significant, into a seed word
// offered on a valid/ready handshake.
// Optional build macro SEED_STUCK_CHECK_EN: discard any word whose bytes are
// all identical and pulse stuck_err instead of delivering it.
module trng_seed_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             seed_valid,
  input  logic                             seed_ready,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] seed_data,
  output logic                             busy,
  output logic                             stuck_err
);

  localparam int SEED_W = DATA_WIDTH * WORD_BYTES;
  localparam int CNT_W  = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  byte_cnt_r;
  logic [SEED_W-1:0] shadow_r;
  logic [SEED_W-1:0] capture_word_s;
  logic [SEED_W-1:0] seed_data_r;
  logic              seed_valid_r;
  logic              stuck_err_r;
  logic              last_byte_s;
  logic              word_stuck_s;

`ifdef SEED_STUCK_CHECK_EN
  // True when every byte lane of the word equals lane 0.
  function automatic logic all_lanes_equal(input logic [SEED_W-1:0] word);
    logic same;
    same = 1'b1;
    for (int i = 1; i < WORD_BYTES; i++) begin
      same = same & (word[i*DATA_WIDTH +: DATA_WIDTH] == word[DATA_WIDTH-1:0]);
    end
    return same;
  endfunction
`endif

  // Shadow word with the byte arriving this cycle merged into lane byte_cnt.
  always_comb begin
    capture_word_s = shadow_r;
    capture_word_s[byte_cnt_r*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
  end

  assign last_byte_s = (byte_cnt_r == LAST_CNT);

`ifdef SEED_STUCK_CHECK_EN
  assign word_stuck_s = all_lanes_equal(capture_word_s);
`else
  assign word_stuck_s = 1'b0;
`endif

  // Next-state decode and the combinational pop request.
  always_comb begin
    state_next_s = state_r;
    fifo_rd_en   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) state_next_s = REQ;
        else        state_next_s = IDLE;
      end
      REQ: begin
        fifo_rd_en = ~fifo_empty;
        if (!fifo_empty) state_next_s = CAP;
        else             state_next_s = REQ;
      end
      CAP: begin
        // A stuck word restarts collection instead of being offered.
        if (last_byte_s && !word_stuck_s) state_next_s = OUT;
        else                              state_next_s = REQ;
      end
      OUT: begin
        // seed_valid is always high in OUT, so seed_ready alone completes it.
        if (seed_ready) begin
          if (enable) state_next_s = REQ;
          else        state_next_s = IDLE;
        end else begin
          state_next_s = OUT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Byte capture, word load and handshake bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_r   <= {CNT_W{1'b0}};
      shadow_r     <= {SEED_W{1'b0}};
      seed_data_r  <= {SEED_W{1'b0}};
      seed_valid_r <= 1'b0;
      stuck_err_r  <= 1'b0;
    end else begin
      stuck_err_r <= 1'b0;
      case (state_r)
        CAP: begin
          shadow_r <= capture_word_s;
          if (last_byte_s) begin
            byte_cnt_r <= {CNT_W{1'b0}};
            if (word_stuck_s) begin
              stuck_err_r <= 1'b1;
            end else begin
              seed_data_r  <= capture_word_s;
              seed_valid_r <= 1'b1;
            end
          end else begin
            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
          end
        end
        OUT: begin
          if (seed_ready) seed_valid_r <= 1'b0;
          else            seed_valid_r <= seed_valid_r;
        end
        default: begin
          seed_valid_r <= seed_valid_r;
        end
      endcase
    end
  end

  assign seed_data  = seed_data_r;
  assign seed_valid = seed_valid_r;
  assign stuck_err  = stuck_err_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: doc/trng_seed_packer.md
Name: trng_seed_packer

Overview:
- Read side of the TRNG byte FIFO: pops 8-bit entropy bytes and packs WORD_BYTES of them into one seed word for the chaos-map key/IV loader.
- Presents each word downstream on a valid/ready handshake.
- Matches the FIFO's registered read port: data appears on fifo_data one cycle after an accepted pop (fifo_rd_en=1 while fifo_empty=0).

Parameters:
- DATA_WIDTH, 8, FIFO byte width.
- WORD_BYTES, 8, bytes per seed word; output width is DATA_WIDTH*WORD_BYTES (64 by default). Legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  packing permitted; sampled only in IDLE and at word handoff.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO pop request (combinational).
- fifo_data  input  DATA_WIDTH  FIFO registered read data.
- seed_valid  output  1  seed_data holds a complete word.
- seed_ready  input  1  downstream accepts word.
- seed_data  output  DATA_WIDTH*WORD_BYTES  packed seed word.
- busy  output  1  state != IDLE.
- stuck_err  output  1  one-cycle pulse on repetition-test failure (optional feature).

Behaviour:
- Reset: state=IDLE, byte_cnt=0, seed_data=0, seed_valid=0, stuck_err=0. fifo_rd_en=0 and busy=0 follow from IDLE.
- States: IDLE, REQ, CAP, OUT.
- IDLE: if enable=1, go to REQ next cycle.
- REQ:
  - fifo_rd_en = ~fifo_empty.
  - If fifo_empty=0, go to CAP. Otherwise stay in REQ; no pop and no timeout.
- CAP:
  - fifo_rd_en=0.
  - Write fifo_data into byte lane byte_cnt of the shadow word: lane 0 = bits [7:0]. The first byte popped is least significant.
  - If byte_cnt==WORD_BYTES-1: load shadow into seed_data, set seed_valid=1, byte_cnt=0, go to OUT.
  - Otherwise byte_cnt++ and go to REQ.
- OUT:
  - seed_valid=1; seed_data is stable until the handshake.
  - On seed_valid & seed_ready: clear seed_valid. Go to REQ if enable=1, else IDLE.
- Throughput: 2 cycles per byte. With a non-empty FIFO and seed_ready held at 1, a WORD_BYTES=8 word takes 16 cycles from REQ entry to seed_valid, plus 1 handoff cycle.
- Exactly one pop per CAP. Never pops while fifo_empty=1. Never pops in CAP, OUT or IDLE, so no byte is lost or duplicated.
- enable dropping mid-word does not abort: the current word completes and is delivered, then the block returns to IDLE.
- seed_ready asserted outside OUT has no effect.
- Asynchronous reset mid-word discards the partial shadow and returns to the reset state. FIFO contents are not restored; bytes already popped are lost.
- byte_cnt width is $clog2(WORD_BYTES); it never exceeds WORD_BYTES-1.

Optional Feature:
- Macro: SEED_STUCK_CHECK_EN.
- Defined:
  - In the final CAP, if all WORD_BYTES bytes (the shadow plus the incoming byte) equal the first byte, the word is discarded.
  - seed_valid stays 0, stuck_err pulses 1 for one cycle, byte_cnt=0, and the FSM returns to REQ to start a fresh word.
- Undefined: no comparison logic; stuck_err tied to 0; every word is delivered.

Test Plan:
- Reset with FIFO holding bytes 0x01..0x08, then enable=1, seed_ready=1 -> exactly 8 pops; seed_data=64'h0807060504030201; seed_valid rises 16 cycles after REQ entry.
- FIFO empty after 3 bytes, refilled 20 cycles later with 0x04..0x08 -> fifo_rd_en stays 0 while empty; word still equals 64'h0807060504030201; no duplicate bytes.
- seed_ready=0 for 10 cycles in OUT -> seed_valid stays 1, seed_data constant, no pops. After seed_ready=1, the next word starts in REQ.
- enable deasserted after the 4th byte -> full word delivered, then IDLE with busy=0 and no further pops.
- reset_n pulsed low during the 5th CAP -> all outputs at reset values immediately. After re-enable, the next word is built from the next 8 FIFO bytes.
- SEED_STUCK_CHECK_EN defined, eight 0xAA bytes followed by 0x10..0x17 -> one stuck_err pulse, no seed_valid for the 0xAA word; the next word is 64'h1716151413121110. Without the macro, 64'hAAAAAAAAAAAAAAAA is delivered and stuck_err stays 0.
